// File: rtl/fx3_packet_scheduler_if.sv
// FX3 packet scheduler bus bundle.
// Capture controls in, FIFO read and GPIF strobes out.
interface fx3_packet_scheduler_if;
  logic        collectData;
  logic        dataAvailable;
  logic        bufferError;
  logic        fx3_ready;
  logic        readData;
  logic        dataValid;
  logic        packetEnd;
  logic        transferActive;
  logic        errorLatched;
  logic [15:0] packetCount;

  modport master (
    output collectData, dataAvailable,
    output bufferError, fx3_ready,
    input  readData, dataValid, packetEnd,
    input  transferActive, errorLatched,
    input  packetCount
  );

  modport slave (
    input  collectData, dataAvailable,
    input  bufferError, fx3_ready,
    output readData, dataValid, packetEnd,
    output transferActive, errorLatched,
    output packetCount
  );
endinterface

// File: rtl/fx3_packet_scheduler.sv
// FX3 packet scheduler: FIFO reads in fixed-size
// USB packets with aligned valid/end strobes.
module fx3_packet_scheduler #(
  parameter int PACKET_WORDS = 8192,
  parameter int DATA_LATENCY = 2
) (
  input logic fx3_clock,
  input logic nReset,
  fx3_packet_scheduler_if.slave io_bus
);
  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, READ, DRAIN, ERROR
  } state_t;

  localparam logic [15:0] LAST_WORD =
    16'(PACKET_WORDS - 1);
  localparam logic [2:0] LAST_DRAIN =
    3'(DATA_LATENCY - 1);

  state_t                  r_state;
  logic [15:0]             r_wordCnt;
  logic [2:0]              r_drainCnt;
  logic                    r_readData;
  logic                    r_transferActive;
  logic                    r_errorLatched;
  logic [15:0]             r_packetCount;
  logic [DATA_LATENCY-1:0] r_validPipe;
  logic [DATA_LATENCY-1:0] r_lastPipe;
  logic                    w_lastRead;

  // readData is high only in READ, so this marks the final read
  assign w_lastRead = r_readData &&
                      (r_wordCnt == LAST_WORD);

  // packet sequencing FSM with registered outputs
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      r_state          <= IDLE;
      r_wordCnt        <= '0;
      r_drainCnt       <= '0;
      r_readData       <= 1'b0;
      r_transferActive <= 1'b0;
      r_errorLatched   <= 1'b0;
      r_packetCount    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (io_bus.collectData) begin
            r_state        <= WAIT_DATA;
            r_packetCount  <= '0;
            r_errorLatched <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (!io_bus.collectData) begin
            r_state <= IDLE;
          end else if (io_bus.bufferError) begin
            r_state        <= ERROR;
            r_errorLatched <= 1'b1;
          end else if (io_bus.dataAvailable &&
                       io_bus.fx3_ready) begin
            r_state          <= READ;
            r_readData       <= 1'b1;
            r_transferActive <= 1'b1;
            r_wordCnt        <= '0;
          end
        end
        READ: begin
          if (io_bus.bufferError)
            r_errorLatched <= 1'b1;
          if (r_wordCnt == LAST_WORD) begin
            r_state    <= DRAIN;
            r_readData <= 1'b0;
            r_drainCnt <= '0;
          end else begin
            r_wordCnt <= r_wordCnt + 16'd1;
          end
        end
        DRAIN: begin
          if (r_drainCnt == LAST_DRAIN) begin
            r_packetCount    <= r_packetCount + 16'd1;
            r_transferActive <= 1'b0;
            if (!io_bus.collectData)
              r_state <= IDLE;
            else if (r_errorLatched)
              r_state <= ERROR;
            else
              r_state <= WAIT_DATA;
          end else begin
            r_drainCnt <= r_drainCnt + 3'd1;
          end
        end
        ERROR: begin
          if (!io_bus.collectData)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // delay read strobe and last marker to match data latency
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      r_validPipe <= '0;
      r_lastPipe  <= '0;
    end else begin
      r_validPipe <= (r_validPipe << 1) |
                     DATA_LATENCY'(r_readData);
      r_lastPipe  <= (r_lastPipe << 1) |
                     DATA_LATENCY'(w_lastRead);
    end
  end

  assign io_bus.readData       = r_readData;
  assign io_bus.dataValid      = r_validPipe[DATA_LATENCY-1];
  assign io_bus.packetEnd      = r_lastPipe[DATA_LATENCY-1];
  assign io_bus.transferActive = r_transferActive;
  assign io_bus.errorLatched   = r_errorLatched;
  assign io_bus.packetCount    = r_packetCount;
endmodule

// File: tb/tb_fx3_packet_scheduler.sv
// Bench for fx3_packet_scheduler: vector table
// plus directed multi-cycle sequences.
module tb_fx3_packet_scheduler;
  localparam int PW = 8;
  localparam int DL = 2;

  logic fx3_clock = 1'b0;
  logic nReset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  fx3_packet_scheduler_if bus();

  fx3_packet_scheduler #(
    .PACKET_WORDS(PW),
    .DATA_LATENCY(DL)
  ) dut (
    .fx3_clock(fx3_clock),
    .nReset(nReset),
    .io_bus(bus)
  );

  always #5 fx3_clock = ~fx3_clock;

  typedef struct {
    logic        c, a, e, r;
    logic [4:0]  o;
    logic [15:0] n;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h",
                  name, act, exp);
  endtask

  function automatic logic [4:0] outs();
    return {bus.readData, bus.dataValid,
            bus.packetEnd, bus.transferActive,
            bus.errorLatched};
  endfunction

  task automatic drive(input logic c, input logic a,
                       input logic e, input logic r);
    bus.collectData   = c;
    bus.dataAvailable = a;
    bus.bufferError   = e;
    bus.fx3_ready     = r;
  endtask

  task automatic step();
    @(posedge fx3_clock);
    @(negedge fx3_clock);
  endtask

  task automatic add(input logic c, input logic a,
                     input logic e, input logic r,
                     input logic [4:0] o,
                     input logic [15:0] n);
    vec_t v;
    v.c = c; v.a = a; v.e = e; v.r = r;
    v.o = o; v.n = n;
    vecs.push_back(v);
  endtask

  initial begin
    int runs[$];
    int gaps[$];
    int cnts[$];
    int run, gap, reads, ends, rdseen;
    logic prev_rd, seen_run;
    logic [15:0] prev_cnt;

    // outputs: {rd, valid, end, active, err}
    add(1,1,0,1, 5'b00000, 16'd0);
    add(1,1,0,1, 5'b10010, 16'd0);
    add(1,0,0,0, 5'b10010, 16'd0);
    for (int i = 3; i <= 8; i++)
      add(1,0,0,0, 5'b11010, 16'd0);
    add(1,0,0,0, 5'b01010, 16'd0);
    add(1,0,0,0, 5'b01110, 16'd0);
    add(1,0,0,0, 5'b00000, 16'd1);
    add(1,0,0,1, 5'b00000, 16'd1);
    add(0,0,0,0, 5'b00000, 16'd1);

    nReset = 1'b0;
    drive(0, 0, 0, 0);
    step();
    step();
    chk("reset_state", {11'b0, outs(), bus.packetCount}, 32'd0);
    nReset = 1'b1;

    // single packet, ready/avail dropped mid-packet
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].c, vecs[i].a, vecs[i].e, vecs[i].r);
      step();
      chk($sformatf("vec%0d", i),
          {11'b0, outs(), bus.packetCount},
          {11'b0, vecs[i].o, vecs[i].n});
    end

    // back-to-back packets
    drive(1, 1, 0, 1);
    step();
    chk("start_clears_count", 32'(bus.packetCount), 32'd0);
    prev_cnt = bus.packetCount;
    prev_rd = 1'b0;
    seen_run = 1'b0;
    run = 0;
    gap = 0;
    for (int k = 0; k < 200 && bus.packetCount != 16'd3; k++) begin
      step();
      if (bus.readData) begin
        if (!prev_rd && seen_run) gaps.push_back(gap);
        run++;
      end else begin
        if (prev_rd) begin
          runs.push_back(run);
          run = 0;
          gap = 0;
          seen_run = 1'b1;
        end
        gap++;
      end
      prev_rd = bus.readData;
      if (bus.packetCount != prev_cnt) begin
        cnts.push_back(int'(bus.packetCount));
        prev_cnt = bus.packetCount;
      end
    end
    chk("b2b_runs", runs.size(), 3);
    foreach (runs[i]) chk($sformatf("b2b_run%0d", i), runs[i], PW);
    chk("b2b_gaps", gaps.size(), 2);
    foreach (gaps[i]) chk($sformatf("b2b_gap%0d", i), gaps[i], DL + 1);
    chk("b2b_counts", cnts.size(), 3);
    foreach (cnts[i]) chk($sformatf("b2b_cnt%0d", i), cnts[i], i + 1);

    // counter wrap from 65535
    for (int k = 0; k < 10 && !bus.readData; k++) step();
    force dut.r_packetCount = 16'hFFFF;
    step();
    release dut.r_packetCount;
    for (int k = 0; k < 40 && bus.packetCount == 16'hFFFF; k++)
      step();
    chk("wrap_to_zero", 32'(bus.packetCount), 32'd0);
    drive(0, 0, 0, 0);
    step();
    step();

    // fx3 not ready holds off reads
    drive(1, 1, 0, 0);
    rdseen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.readData) rdseen++;
    end
    chk("not_ready_no_read", rdseen, 0);
    drive(1, 1, 0, 1);
    step();
    chk("read_after_ready", 32'(bus.readData), 32'd1);

    // stop capture after 3 reads, ready dropped
    reads = 1;
    ends = 0;
    drive(1, 1, 0, 0);
    for (int k = 0; k < 5 && reads < 3; k++) begin
      step();
      if (bus.readData) reads++;
    end
    drive(0, 0, 0, 0);
    for (int k = 0; k < 30 && bus.transferActive; k++) begin
      step();
      reads += int'(bus.readData);
      ends += int'(bus.packetEnd);
    end
    chk("stop_active_done", 32'(bus.transferActive), 32'd0);
    chk("stop_reads", reads, PW);
    chk("stop_ends", ends, 1);
    chk("stop_count", 32'(bus.packetCount), 32'd1);
    step();
    step();
    chk("stop_idle", 32'(outs()), 32'd0);

    // overflow during read
    drive(1, 1, 0, 1);
    for (int k = 0; k < 10 && !bus.readData; k++) step();
    reads = int'(bus.readData);
    step();
    reads += int'(bus.readData);
    drive(1, 1, 1, 1);
    step();
    reads += int'(bus.readData);
    chk("err_immediate", 32'(bus.errorLatched), 32'd1);
    drive(1, 1, 0, 1);
    for (int k = 0; k < 30 && bus.transferActive; k++) begin
      step();
      reads += int'(bus.readData);
    end
    chk("err_reads", reads, PW);
    chk("err_count", 32'(bus.packetCount), 32'd1);
    rdseen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.readData || bus.transferActive) rdseen++;
    end
    chk("err_no_reads", rdseen, 0);
    chk("err_held", 32'(bus.errorLatched), 32'd1);
    drive(0, 1, 0, 1);
    step();
    chk("err_idle_sticky", 32'(outs()), 32'd1);
    drive(1, 1, 0, 1);
    step();
    chk("restart_clears",
        {15'b0, bus.errorLatched, bus.packetCount}, 32'd0);

    // async reset mid-read
    for (int k = 0; k < 40 && bus.packetCount != 16'd1; k++)
      step();
    for (int k = 0; k < 10 && !bus.readData; k++) step();
    step();
    step();
    chk("pre_reset_busy", 32'(outs()), 32'b11010);
    #1 nReset = 1'b0;
    #1;
    chk("async_reset",
        {11'b0, outs(), bus.packetCount}, 32'd0);
    @(negedge fx3_clock);
    nReset = 1'b1;
    step();
    chk("post_reset_wait", 32'(outs()), 32'd0);
    step();
    chk("post_reset_read", 32'(outs()), 32'b10010);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
